// File: rtl/load_store_unit.sv
// Load/store unit between the MIPS datapath and a word-addressed data memory.
// Optional macro LSU_MISALIGN_TRAP_EN: when defined misaligned half/word requests fault,
// otherwise they are force-aligned and proceed.
module load_store_unit #(
  parameter int unsigned WORD_AW   = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic               req_we,
  input  logic [1:0]         req_size,
  input  logic               req_unsigned,
  input  logic [31:0]        req_addr,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic               resp_fault,
  output logic               mem_we,
  output logic [WORD_AW-1:0] mem_addr,
  output logic [31:0]        mem_wd,
  input  logic [31:0]        mem_rd
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    WRITE  = 2'b10,
    RESP   = 2'b11
  } state_t;

  localparam logic [32:0] WIN_BYTES = 33'd4 << WORD_AW;
  localparam logic [32:0] WIN_END   = {1'b0, BASE_ADDR} + WIN_BYTES;

  state_t               state_r;
  state_t               next_state_s;
  logic                 we_r;
  logic [1:0]           size_r;
  logic                 uns_r;
  logic [1:0]           off_r;
  logic [31:0]          wdata_r;
  logic                 resp_valid_r;
  logic [31:0]          resp_rdata_r;
  logic                 resp_fault_r;
  logic                 mem_we_r;
  logic [WORD_AW-1:0]   mem_addr_r;
  logic [31:0]          mem_wd_r;

  logic                 accept_s;
  logic                 misalign_s;
  logic [31:0]          aligned_addr_s;
  logic                 in_range_s;
  logic                 fault_s;
  logic [31:0]          offset_s;
  logic [WORD_AW-1:0]   word_idx_s;
  logic                 mem_we_next_s;

  // Big-endian lane pick with sign or zero extension.
  function automatic logic [31:0] lane_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [4:0]  shift_v;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] res_v;
    shift_v = 5'd24 - {off, 3'b000};
    byte_v  = 8'(word >> shift_v);
    half_v  = off[1] ? word[15:0] : word[31:16];
    case (size)
      2'b00:   res_v = uns ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
      2'b01:   res_v = uns ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
      default: res_v = word;
    endcase
    return res_v;
  endfunction

  // Replace one big-endian lane of word with the low bits of wdata.
  function automatic logic [31:0] lane_merge(input logic [31:0] word, input logic [31:0] wdata,
                                             input logic [1:0] size, input logic [1:0] off);
    logic [4:0]  shift_v;
    logic [31:0] mask_v;
    logic [31:0] res_v;
    shift_v = 5'd24 - {off, 3'b000};
    mask_v  = 32'h0000_00FF << shift_v;
    case (size)
      2'b00:   res_v = (word & ~mask_v) | ({24'd0, wdata[7:0]} << shift_v);
      2'b01:   res_v = off[1] ? {word[31:16], wdata[15:0]} : {wdata[15:0], word[15:0]};
      default: res_v = wdata;
    endcase
    return res_v;
  endfunction

  assign accept_s   = req_valid && (state_r == IDLE);
  assign req_ready  = (state_r == IDLE);
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_fault = resp_fault_r;
  assign mem_we     = mem_we_r;
  assign mem_addr   = mem_addr_r;
  assign mem_wd     = mem_wd_r;

  // Alignment handling: trap on misalignment, or silently clear the low address bits.
  always_comb begin
    misalign_s     = 1'b0;
    aligned_addr_s = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_size)
      2'b01:   misalign_s = req_addr[0];
      2'b10:   misalign_s = (req_addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
`else
    case (req_size)
      2'b01:   aligned_addr_s = {req_addr[31:1], 1'b0};
      2'b10:   aligned_addr_s = {req_addr[31:2], 2'b00};
      default: aligned_addr_s = req_addr;
    endcase
`endif
  end

  // Window check and word index of the request.
  always_comb begin
    in_range_s = ({1'b0, aligned_addr_s} >= {1'b0, BASE_ADDR}) &&
                 ({1'b0, aligned_addr_s} < WIN_END);
    offset_s   = aligned_addr_s - BASE_ADDR;
    word_idx_s = WORD_AW'(offset_s >> 2);
    fault_s    = (req_size == 2'b11) || misalign_s || !in_range_s;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = fault_s ? RESP : ACCESS;
        end else begin
          next_state_s = IDLE;
        end
      end
      ACCESS: begin
        if (we_r && (size_r != 2'b10)) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = RESP;
        end
      end
      WRITE:   next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Write enable for the coming cycle: ACCESS of a word store, or WRITE of a sub-word store.
  always_comb begin
    mem_we_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s && !fault_s && req_we && (req_size == 2'b10)) begin
          mem_we_next_s = 1'b1;
        end else begin
          mem_we_next_s = 1'b0;
        end
      end
      ACCESS: begin
        if (we_r && (size_r != 2'b10)) begin
          mem_we_next_s = 1'b1;
        end else begin
          mem_we_next_s = 1'b0;
        end
      end
      default: mem_we_next_s = 1'b0;
    endcase
  end

  // Request capture, memory port and response registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      we_r         <= 1'b0;
      size_r       <= 2'b00;
      uns_r        <= 1'b0;
      off_r        <= 2'b00;
      wdata_r      <= 32'd0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'd0;
      resp_fault_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= '0;
      mem_wd_r     <= 32'd0;
    end else begin
      resp_valid_r <= (next_state_s == RESP);
      mem_we_r     <= mem_we_next_s;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            we_r         <= req_we;
            size_r       <= req_size;
            uns_r        <= req_unsigned;
            off_r        <= aligned_addr_s[1:0];
            wdata_r      <= req_wdata;
            resp_fault_r <= fault_s;
            resp_rdata_r <= 32'd0;
            if (!fault_s) begin
              mem_addr_r <= word_idx_s;
              if (req_we && (req_size == 2'b10)) begin
                mem_wd_r <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          if (!we_r) begin
            resp_rdata_r <= lane_extract(mem_rd, size_r, off_r, uns_r);
          end else if (size_r != 2'b10) begin
            // The merged word is written from the register during WRITE.
            mem_wd_r <= lane_merge(mem_rd, wdata_r, size_r, off_r);
          end
        end
        RESP: begin
          resp_fault_r <= 1'b0;
          resp_rdata_r <= 32'd0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed and randomized bench for load_store_unit against a byte-level reference model.
module tb_load_store_unit;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cnt = 0;
  logic [31:0] mem     [0:1023];
  logic [31:0] ref_mem [0:1023];

  load_store_unit dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clock = ~clock;

  assign mem_rd = mem[mem_addr];

  always @(posedge clock) begin
    if (mem_we) begin
      mem[mem_addr] = mem_wd;
      wr_cnt = wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] get_byte(input logic [31:0] b);
    return 8'((ref_mem[b[11:2]] >> (8 * (3 - int'(b[1:0])))) & 32'hFF);
  endfunction

  task automatic set_byte(input logic [31:0] b, input logic [7:0] v);
    int sh;
    sh = 8 * (3 - int'(b[1:0]));
    ref_mem[b[11:2]] = (ref_mem[b[11:2]] & ~(32'hFF << sh)) | ({24'd0, v} << sh);
  endtask

  // Byte-level reference: memory viewed as a big-endian byte array of 4096 bytes at base 0.
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic fault, output logic [31:0] rdata, output int lat, output int nwr);
    int n;
    logic [31:0] a;
    logic [31:0] v;
    n = (size == 2'b11) ? 1 : (1 << size);
    fault = (size == 2'b11);
    a = addr;
    if (!fault && (addr % n) != 0) begin
`ifdef LSU_MISALIGN_TRAP_EN
      fault = 1'b1;
`else
      a = addr - (addr % n);
`endif
    end
    if (a >= 32'd4096) fault = 1'b1;
    rdata = 32'd0;
    lat = 1;
    nwr = 0;
    if (!fault) begin
      if (we) begin
        for (int k = 0; k < n; k++) set_byte(a + k, 8'(wdata >> (8 * (n - 1 - k))));
        nwr = 1;
        lat = (n == 4) ? 2 : 3;
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = (v << 8) | {24'd0, get_byte(a + k)};
        if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        rdata = v;
        lat = 2;
      end
    end
  endtask

  task automatic mem_sync(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, ".memsync"}, bad, 32'd0);
  endtask

  task automatic do_req(input string tag, input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
    logic e_fault;
    logic [31:0] e_rdata;
    int e_lat, e_nwr, lat, w0;
    logic got;
    model(we, size, uns, addr, wdata, e_fault, e_rdata, e_lat, e_nwr);
    @(negedge clock);
    chk({tag, ".ready"}, req_ready, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    w0 = wr_cnt;
    @(posedge clock);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clock);
      lat++;
      if (lat == 1) begin
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      end
      if (resp_valid) got = 1'b1;
    end
    chk({tag, ".lat"}, lat, e_lat);
    chk({tag, ".fault"}, resp_fault, {31'd0, e_fault});
    chk({tag, ".rdata"}, resp_rdata, e_rdata);
    chk({tag, ".writes"}, wr_cnt - w0, e_nwr);
    if (got) begin
      @(negedge clock);
      chk({tag, ".pulse"}, resp_valid, 32'd0);
    end
    mem_sync(tag);
  endtask

  task automatic preload(input int idx, input logic [31:0] v);
    mem[idx] = v;
    ref_mem[idx] = v;
  endtask

  initial begin
    logic [31:0] pa [3];
    logic [31:0] e_rd [3];
    logic [31:0] g_rd [3];
    int acc_cyc [3];
    int idx, nresp, w0, dummy_lat, dummy_nwr;
    logic dummy_fault;

    for (int i = 0; i < 1024; i++) preload(i, $urandom);
    reset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
    #12;
    chk("rst.ready", req_ready, 32'd1);
    chk("rst.resp_valid", resp_valid, 32'd0);
    chk("rst.fault", resp_fault, 32'd0);
    chk("rst.mem_we", mem_we, 32'd0);
    chk("rst.mem_addr", mem_addr, 32'd0);
    chk("rst.mem_wd", mem_wd, 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;

    do_req("sw10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    do_req("lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

    preload(4, 32'h80FF7F01);
    do_req("lb10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
    do_req("lbu10", 1'b0, 2'b00, 1'b1, 32'h10, 32'h0);
    do_req("lb12",  1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    do_req("lh12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
    do_req("lhu10", 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);

    preload(4, 32'h11223344);
    do_req("sb11", 1'b1, 2'b00, 1'b0, 32'h11, 32'hAA);
    do_req("sh12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hBBCC);

    do_req("lw12",   1'b0, 2'b10, 1'b0, 32'h12, 32'h0);
    do_req("sh13",   1'b1, 2'b01, 1'b0, 32'h13, 32'h1234);
    do_req("size11", 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
    do_req("lw1000", 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0);
    do_req("lwffc",  1'b0, 2'b10, 1'b0, 32'hFFC, 32'h0);
    do_req("sbfff",  1'b1, 2'b00, 1'b0, 32'hFFF, 32'h5A);
    do_req("swhigh", 1'b1, 2'b10, 1'b0, 32'h8000_0010, 32'h1);

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra;
      ra = (($urandom % 8) == 0) ? $urandom : 32'($urandom_range(0, 32'h1010));
      do_req("rnd", 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra, $urandom);
    end

    // Reset while a sub-word store sits in WRITE: the write must be dropped.
    preload(4, 32'h11223344);
    @(negedge clock);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h11; req_wdata = 32'h55;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    @(negedge clock);
    chk("rstw.mem_we_before", mem_we, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rstw.mem_we", mem_we, 32'd0);
    chk("rstw.resp_valid", resp_valid, 32'd0);
    chk("rstw.ready", req_ready, 32'd1);
    chk("rstw.mem_wd", mem_wd, 32'd0);
    w0 = wr_cnt;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rstw.no_resp", resp_valid, 32'd0);
    end
    chk("rstw.ready_after", req_ready, 32'd1);
    chk("rstw.writes", wr_cnt - w0, 32'd0);
    chk("rstw.word4", mem[4], 32'h11223344);

    // Three loads with req_valid held high.
    for (int k = 0; k < 3; k++) begin
      pa[k] = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
      model(1'b0, 2'b10, 1'b0, pa[k], 32'd0, dummy_fault, e_rd[k], dummy_lat, dummy_nwr);
      g_rd[k] = 32'd0;
      acc_cyc[k] = -100;
    end
    idx = 0;
    nresp = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clock);
      if (resp_valid) begin
        if (nresp < 3) g_rd[nresp] = resp_rdata;
        nresp++;
      end
      if (req_ready) begin
        if (idx < 3) begin
          req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0;
          req_addr = pa[idx];
          acc_cyc[idx] = cyc;
          idx++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    chk("pipe.accepts", idx, 32'd3);
    chk("pipe.gap01", acc_cyc[1] - acc_cyc[0], 32'd3);
    chk("pipe.gap12", acc_cyc[2] - acc_cyc[1], 32'd3);
    chk("pipe.nresp", nresp, 32'd3);
    for (int k = 0; k < 3; k++) chk("pipe.rdata", g_rd[k], e_rd[k]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the MIPS datapath and the word-addressed data memory (1024 x 32, combinational read, synchronous write on `clock` when `we` is high).
- Turns LB/LBU/LH/LHU/LW/SB/SH/SW requests into word accesses.
- Sign- or zero-extends load data and does read-modify-write for sub-word stores.
- Flags bad requests. Request/response handshake; one request in flight.

Parameters:
- WORD_AW, 10, word-index width driven on mem_addr.
- BASE_ADDR, 32'h0000_0000, byte base of the data window. Window size is 4 << WORD_AW bytes.

Ports:
- clock  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- req_unsigned  in  1  zero-extend load (LBU/LHU); ignored for stores and words.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle response strobe.
- resp_rdata  out  32  extended load data; 0 for stores and faults.
- resp_fault  out  1  valid with resp_valid; request was rejected.
- mem_we  out  1  data-memory write enable.
- mem_addr  out  WORD_AW  data-memory word index.
- mem_wd  out  32  data-memory write data.
- mem_rd  in  32  data-memory read data (combinational from mem_addr).

Behaviour:
- Reset (async, reset_n=0):
  - State goes to IDLE.
  - req_ready=1; resp_valid, resp_fault, mem_we = 0; resp_rdata, mem_addr, mem_wd = 0.
  - Takes effect immediately mid-operation. Any pending write is dropped; mem_we falls without waiting for a clock.
- States:
  - IDLE: req_ready=1. Accept when req_valid & req_ready. Latch we, size, unsigned, addr, wdata.
  - Fault check at accept. A fault goes straight to RESP with resp_fault=1 and causes no memory access. Faults are:
    - size=11;
    - misalignment (half with addr[0]=1, word with addr[1:0]!=0);
    - addr outside [BASE_ADDR, BASE_ADDR + (4 << WORD_AW) - 1].
  - A good request goes to ACCESS.
- ACCESS: mem_addr = (addr_q - BASE_ADDR) >> 2.
  - Load: register the extracted lane of mem_rd into resp_rdata, then go to RESP.
  - Word store: mem_we=1, mem_wd=wdata_q, then go to RESP.
  - Sub-word store: latch mem_rd into merge_q, then go to WRITE. No write happens this cycle.
- WRITE: mem_addr held; mem_we=1; mem_wd = merge_q with the target lane replaced by the low bits of wdata_q. Then go to RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0, then IDLE. The response cannot be stalled.
- Latency from accept edge to resp_valid:
  - load and word store: 2 cycles;
  - sub-word store: 3 cycles;
  - fault: 1 cycle.
- Back-to-back throughput: one request per 3 cycles (4 for sub-word stores).
- Big-endian lanes:
  - byte offset 0 -> [31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0];
  - half offset 0 -> [31:16], 2 -> [15:0].
- Load extension: signed loads replicate the lane MSB; unsigned loads fill with zeros.
- Inputs are ignored outside IDLE. req_* may change freely after accept.
- mem_we is high only in ACCESS (word store) or WRITE. At most one write per request.
- Outside ACCESS/WRITE, mem_addr holds its last value and mem_wd is don't-care-stable (held).

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned half/word requests fault as above.
- Undefined: misalignment is not a fault. The address is force-aligned (half clears addr[0], word clears addr[1:0]) and the request proceeds normally. Range and size=11 faults remain.

Test Plan:
- Reset, then SW addr 0x10 wdata 0xDEADBEEF, then LW 0x10 -> word 4 written once; load resp_rdata=0xDEADBEEF, resp_fault=0, resp_valid 2 cycles after each accept.
- Word 4 = 0x80FF7F01; LB 0x10 / LBU 0x10 / LB 0x12 / LH 0x12 / LHU 0x10 -> 0xFFFFFF80 / 0x00000080 / 0x0000007F / 0x00007F01 / 0x000080FF.
- Word 4 = 0x11223344; SB 0x11 wdata 0xAA, then SH 0x12 wdata 0xBBCC -> word 4 = 0x11AA3344, then 0x11AABBCC; each mem_we pulses exactly once, in WRITE; resp 3 cycles after accept.
- LW 0x12, SH 0x13, size=11, and LW 0x1000 (WORD_AW=10) -> resp_fault=1 one cycle after accept, rdata=0, no mem_we. Without the macro, LW 0x12 instead returns word 4.
- SB accepted, reset_n dropped during WRITE -> mem_we falls immediately, no resp_valid, memory unchanged, req_ready=1 after release.
- req_valid held high continuously with 3 loads -> accepts spaced 3 cycles, req_ready low in ACCESS/RESP, exactly 3 resp_valid pulses in order.
